// File: rtl/gpio_apb_pkg.sv
// gpio_apb_pkg: shared FSM state encodings and APB data/strobe widths for the gpio APB arbiter
package gpio_apb_pkg;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/gpio_apb_arbiter_if.sv
// gpio_apb_arbiter_if: requester bus (req_*/rsp_*) plus APB bus (p*) between requesters, arbiter and gpio_controller
// master: arbiter view (takes requests and APB slave responses, drives responses and APB requests)
// slave: environment view (requesters and APB slave)
interface gpio_apb_arbiter_if #(parameter int NUM_REQ = 3, parameter int ADDR_W = 12);
  import gpio_apb_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0] req_strb;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic pwrite;
  logic psel;
  logic penable;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master(
    input req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    output rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pstrb, pwdata
  );
  modport slave(
    output req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    input rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pstrb, pwdata
  );
endinterface

// File: rtl/gpio_rr_arbiter.sv
// gpio_rr_arbiter: combinational round-robin pick; ports req/ptr in, one-hot grant, binary idx and any out
module gpio_rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input logic [NUM_REQ-1:0] req,
  input logic [IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic any
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0] sum;
  assign any = |req;
  // rotate so bit 0 is the pointer position, take the lowest set bit, then map back modulo NUM_REQ
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    sum = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (rot[j]) sum = {1'b0, ptr} + (IDX_W+1)'(j);
    idx = sum >= (IDX_W+1)'(NUM_REQ) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin share of one APB slave port among NUM_REQ requesters with timeout
// ports: clk, rst (async active-high), bus (gpio_apb_arbiter_if.master: req_*/rsp_* requester side, p* APB side)
module gpio_apb_arbiter
  import gpio_apb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  gpio_apb_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [1:0] state;
  logic [IDX_W-1:0] ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0] cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0] idx;
  logic any;
  gpio_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.paddr <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      bus.pstrb <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: if (any) begin
          gnt <= grant;
          bus.paddr <= bus.req_addr[idx*ADDR_W +: ADDR_W];
          bus.pwrite <= bus.req_write[idx];
          bus.pwdata <= bus.req_wdata[idx*DATA_W +: DATA_W];
          bus.pstrb <= bus.req_write[idx] ? bus.req_strb[idx*STRB_W +: STRB_W] : '0;
          bus.psel <= 1'b1;
          ptr <= idx == IDX_W'(NUM_REQ - 1) ? '0 : idx + 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (bus.pready || cnt == CNT_W'(TIMEOUT - 1)) begin
          // pready takes priority over a coincident timeout
          bus.rsp_rdata <= bus.pready && !bus.pwrite ? bus.prdata : '0;
          bus.rsp_err <= bus.pready ? bus.pslverr : 1'b1;
          bus.rsp_valid <= gnt;
          bus.psel <= 1'b0;
          bus.penable <= 1'b0;
          cnt <= '0;
          state <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
